// File: rtl/breadboard_sequencer.sv
// Playback controller: steps the Breadboard row index through a latched range, one row per beat, and registers each looked-up note.
// Latency: lut_idx = first_idx one cycle after an accepted start; note_out/note_valid follow one cycle after each new row.
// Backpressure: none; pause freezes stepping, stop aborts to idle and silences note_out.
module breadboard_sequencer #(
    parameter int TEMPO_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               loop_en,
    input  logic [3:0]         first_idx,
    input  logic [3:0]         last_idx,
    input  logic [TEMPO_W-1:0] beat_len,
    output logic [3:0]         lut_idx,
    input  logic [9:0]         lut_data,
    output logic [9:0]         note_out,
    output logic               note_valid,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [3:0]         first_q, first_d;
    logic [3:0]         last_q, last_d;
    logic [TEMPO_W-1:0] beat_q, beat_d;
    logic [TEMPO_W-1:0] cnt_q, cnt_d;
    logic [9:0]         note_q, note_d;
    logic               nv_q, nv_d;
    logic               cap_q, cap_d;
    logic [TEMPO_W-1:0] beat_eff;

    assign beat_eff = (beat_len == '0) ? TEMPO_W'(1) : beat_len;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        first_d = first_q;
        last_d  = last_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        note_d  = note_q;
        nv_d    = 1'b0;
        cap_d   = 1'b0;

        // cap_q marks that lut_idx changed on the previous edge, so lut_data now reflects the new row
        if (cap_q) begin
            note_d = lut_data;
            nv_d   = 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start && !stop) begin
                    state_d = S_PLAY;
                    idx_d   = first_idx;
                    first_d = first_idx;
                    last_d  = last_idx;
                    beat_d  = beat_eff;
                    cnt_d   = beat_eff - TEMPO_W'(1);
                    cap_d   = 1'b1;
                end
            end
            S_PLAY, S_PAUSE: begin
                state_d = pause ? S_PAUSE : S_PLAY;
                // the beat counter runs in any busy cycle with pause low, so a pause of P cycles stretches a row by exactly P
                if (!pause) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - TEMPO_W'(1);
                    end else begin
                        cnt_d = beat_q - TEMPO_W'(1);
                        if (idx_q != last_q) begin
                            idx_d = idx_q + 4'd1;
                            cap_d = 1'b1;
                        end else if (loop_en) begin
                            idx_d = first_q;
                            cap_d = 1'b1;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (stop && state_q != S_IDLE) begin
            state_d = S_IDLE;
            idx_d   = idx_q;
            cap_d   = 1'b0;
            note_d  = '0;
            nv_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
            beat_q  <= TEMPO_W'(1);
            cnt_q   <= '0;
            note_q  <= '0;
            nv_q    <= 1'b0;
            cap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            first_q <= first_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            note_q  <= note_d;
            nv_q    <= nv_d;
            cap_q   <= cap_d;
        end
    end

    assign lut_idx    = idx_q;
    assign note_out   = note_q;
    assign note_valid = nv_q;
    assign busy       = (state_q == S_PLAY) || (state_q == S_PAUSE);
    assign done       = (state_q == S_DONE);

endmodule
